// File: rtl/result_batch_accumulator.sv
// result_batch_accumulator
// Collects N_SAMPLES accepted results from the non-stalling datapath, forms the
// batch sum and maximum, and offers them downstream over valid/ready. While a
// completed batch waits for downstream, incoming results are dropped and counted.
module result_batch_accumulator #(
  parameter int DATA_W    = 4,
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic [DATA_W-1:0] max_out,
  output logic [7:0]        drop_cnt
);

  // A one-sample batch still needs a one-bit counter to keep the declarations legal.
  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   max_out_q, max_out_d;
  logic [7:0]          drop_q, drop_d;

  logic                accept;
  logic                drop_evt;
  logic [ACC_W-1:0]    data_ext;
  logic [DATA_W-1:0]   max_new;
  logic [ACC_W-1:0]    acc_new;

  // Handshake qualifiers and the per-sample arithmetic shared by both update paths.
  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    out_valid = (state_q == ST_HOLD);
    accept    = in_valid && in_ready;
    drop_evt  = in_valid && !in_ready;
    data_ext  = ACC_W'(in_data);
    acc_new   = acc_q + data_ext;
    max_new   = (in_data > max_q) ? in_data : max_q;
  end

  // Next-state logic: collect samples, publish the batch, wait for downstream.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    sum_d     = sum_q;
    max_out_d = max_out_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            // Last sample of the batch: publish including this sample and restart.
            sum_d     = acc_new;
            max_out_d = max_new;
            acc_d     = '0;
            cnt_d     = '0;
            max_d     = '0;
            state_d   = ST_HOLD;
          end else begin
            acc_d = acc_new;
            max_d = max_new;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        // The result registers stay frozen; leaving HOLD costs one bubble cycle.
        if (out_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // Saturating count of results lost while a batch was pending.
  always_comb begin
    drop_d = drop_q;
    if (drop_evt && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State and datapath registers; reset discards any partial or pending batch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_COLLECT;
      acc_q     <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      sum_q     <= '0;
      max_out_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      sum_q     <= sum_d;
      max_out_q <= max_out_d;
      drop_q    <= drop_d;
    end
  end

  assign sum_out  = sum_q;
  assign max_out  = max_out_q;
  assign drop_cnt = drop_q;

endmodule
